// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 matrix keypad scanner with row rotation, debounce
// and single-strobe key acceptance.
// Optional feature macro: KEYPAD_RELEASE_CLEAR_EN -- when defined, the
// reported key code is cleared to 1111 (esnumero=0) once the key is released.
module keypad_scanner #(
  parameter int SCAN_DIV     = 50000,
  parameter int DEBOUNCE_CNT = 4
) (
  input  logic       CLK,
  input  logic       Reset,
  input  logic [3:0] columna,
  output logic [3:0] fila,
  output logic [3:0] tvalida,
  output logic       esnumero,
  output logic       tecla_lista
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DEB_W = $clog2(DEBOUNCE_CNT + 1);

  typedef enum logic [1:0] {
    SCAN,
    DEBOUNCE,
    VALID,
    WAIT_RELEASE
  } state_t;

  state_t             state_q, state_d;
  logic [3:0]         col_meta_q, col_meta_d;
  logic [3:0]         col_sync_q, col_sync_d;
  logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;
  logic [DEB_W-1:0]   deb_cnt_q, deb_cnt_d;
  logic [3:0]         fila_q, fila_d;
  logic [1:0]         row_q, row_d;
  logic [1:0]         col_q, col_d;
  logic [3:0]         tvalida_q, tvalida_d;
  logic               esnumero_q, esnumero_d;
  logic               tecla_lista_q, tecla_lista_d;

  logic               tick;
  logic               single_low;
  logic [1:0]         low_col;
  logic [1:0]         fila_row;
  logic [3:0]         fila_next;
  logic [3:0]         key_code_w;
  logic [DEB_W-1:0]   deb_cnt_inc;

  // Map a (row, column) position of the keypad to its 4-bit key code.
  function automatic logic [3:0] key_code(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] code;
    case ({row, col})
      4'h0: code = 4'h1;  4'h1: code = 4'h2;  4'h2: code = 4'h3;  4'h3: code = 4'hA;
      4'h4: code = 4'h4;  4'h5: code = 4'h5;  4'h6: code = 4'h6;  4'h7: code = 4'hB;
      4'h8: code = 4'h7;  4'h9: code = 4'h8;  4'hA: code = 4'h9;  4'hB: code = 4'hC;
      4'hC: code = 4'hE;  4'hD: code = 4'h0;  4'hE: code = 4'hF;  default: code = 4'hD;
    endcase
    return code;
  endfunction

  // Column synchronizer and free-running scan-tick divider.
  always_comb begin
    col_meta_d = columna;
    col_sync_d = col_meta_q;
    tick       = (div_cnt_q == DIV_W'(SCAN_DIV - 1));
    div_cnt_d  = tick ? '0 : div_cnt_q + DIV_W'(1);
  end

  // Decode the synchronized columns and the currently driven row.
  always_comb begin
    single_low = 1'b0;
    low_col    = 2'd0;
    case (col_sync_q)
      4'b1110: begin single_low = 1'b1; low_col = 2'd0; end
      4'b1101: begin single_low = 1'b1; low_col = 2'd1; end
      4'b1011: begin single_low = 1'b1; low_col = 2'd2; end
      4'b0111: begin single_low = 1'b1; low_col = 2'd3; end
      default: begin single_low = 1'b0; low_col = 2'd0; end
    endcase
    fila_row = 2'd0;
    case (fila_q)
      4'b1101: fila_row = 2'd1;
      4'b1011: fila_row = 2'd2;
      4'b0111: fila_row = 2'd3;
      default: fila_row = 2'd0;
    endcase
    fila_next   = {fila_q[2:0], fila_q[3]};
    key_code_w  = key_code(row_q, col_q);
    deb_cnt_inc = deb_cnt_q + DEB_W'(1);
  end

  // Scanner FSM next-state and output logic; leaving a held state always
  // advances to the next row so rotation picks up where the key was found.
  always_comb begin
    state_d       = state_q;
    fila_d        = fila_q;
    row_d         = row_q;
    col_d         = col_q;
    deb_cnt_d     = deb_cnt_q;
    tvalida_d     = tvalida_q;
    esnumero_d    = esnumero_q;
    tecla_lista_d = 1'b0;
    case (state_q)
      SCAN: begin
        if (tick) begin
          if (single_low) begin
            row_d     = fila_row;
            col_d     = low_col;
            deb_cnt_d = '0;
            state_d   = DEBOUNCE;
          end else begin
            fila_d = fila_next;
          end
        end
      end
      DEBOUNCE: begin
        if (tick) begin
          if (single_low && (low_col == col_q)) begin
            deb_cnt_d = deb_cnt_inc;
            if (deb_cnt_inc == DEB_W'(DEBOUNCE_CNT)) begin
              state_d = VALID;
            end
          end else begin
            fila_d  = fila_next;
            state_d = SCAN;
          end
        end
      end
      VALID: begin
        tvalida_d     = key_code_w;
        esnumero_d    = (key_code_w <= 4'd9);
        tecla_lista_d = 1'b1;
        deb_cnt_d     = '0;
        state_d       = WAIT_RELEASE;
      end
      WAIT_RELEASE: begin
        if (tick) begin
          if (col_sync_q == 4'b1111) begin
            deb_cnt_d = deb_cnt_inc;
            if (deb_cnt_inc == DEB_W'(DEBOUNCE_CNT)) begin
              deb_cnt_d = '0;
              fila_d    = fila_next;
              state_d   = SCAN;
`ifdef KEYPAD_RELEASE_CLEAR_EN
              tvalida_d  = 4'b1111;
              esnumero_d = 1'b0;
`endif
            end
          end else begin
            deb_cnt_d = '0;
          end
        end
      end
      default: begin
        state_d = SCAN;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q       <= SCAN;
      col_meta_q    <= 4'b1111;
      col_sync_q    <= 4'b1111;
      div_cnt_q     <= '0;
      deb_cnt_q     <= '0;
      fila_q        <= 4'b1110;
      row_q         <= 2'd0;
      col_q         <= 2'd0;
      tvalida_q     <= 4'b1111;
      esnumero_q    <= 1'b0;
      tecla_lista_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      col_meta_q    <= col_meta_d;
      col_sync_q    <= col_sync_d;
      div_cnt_q     <= div_cnt_d;
      deb_cnt_q     <= deb_cnt_d;
      fila_q        <= fila_d;
      row_q         <= row_d;
      col_q         <= col_d;
      tvalida_q     <= tvalida_d;
      esnumero_q    <= esnumero_d;
      tecla_lista_q <= tecla_lista_d;
    end
  end

  assign fila        = fila_q;
  assign tvalida     = tvalida_q;
  assign esnumero    = esnumero_q;
  assign tecla_lista = tecla_lista_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: self-checking bench for keypad_scanner with a simulated
// 4x4 switch matrix and a key-map reference model.
module tb_keypad_scanner;

  localparam int SCAN_DIV     = 4;
  localparam int DEBOUNCE_CNT = 3;

  logic       CLK = 1'b0;
  logic       Reset = 1'b1;
  logic [3:0] columna;
  logic [3:0] fila;
  logic [3:0] tvalida;
  logic       esnumero;
  logic       tecla_lista;

  logic [15:0] key_down = '0;
  int          checks = 0;
  int          passes = 0;
  int          strobe_cnt = 0;
  logic [3:0]  strobe_code = 4'b1111;
  logic        strobe_es = 1'b0;

  keypad_scanner #(
    .SCAN_DIV    (SCAN_DIV),
    .DEBOUNCE_CNT(DEBOUNCE_CNT)
  ) dut (
    .CLK        (CLK),
    .Reset      (Reset),
    .columna    (columna),
    .fila       (fila),
    .tvalida    (tvalida),
    .esnumero   (esnumero),
    .tecla_lista(tecla_lista)
  );

  // Free-running clock.
  always #5 CLK = ~CLK;

  // Switch matrix: a closed key pulls its column low while its row is driven low.
  always_comb begin
    columna = 4'b1111;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (key_down[r*4+c] && (fila[r] === 1'b0)) columna[c] = 1'b0;
      end
    end
  end

  // Strobe monitor: counts accepted keys and remembers the reported code.
  always @(negedge CLK) begin
    if (tecla_lista === 1'b1) begin
      strobe_cnt  = strobe_cnt + 1;
      strobe_code = tvalida;
      strobe_es   = esnumero;
    end
  end

  // Reference key map, read from the printed keypad legend.
  function automatic logic [3:0] ref_code(input int r, input int c);
    string keymap;
    byte   ch;
    keymap = "123A456B789C*0#D";
    ch = keymap[r*4+c];
    if (ch >= "0" && ch <= "9") return 4'(ch - "0");
    if (ch >= "A" && ch <= "D") return 4'(ch - "A" + 10);
    if (ch == "*") return 4'd14;
    return 4'd15;
  endfunction

  function automatic logic ref_esnum(input logic [3:0] code);
    return (int'(code) < 10);
  endfunction

  function automatic logic [3:0] row_drive(input int r);
    return 4'b1111 ^ (4'b0001 << r);
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic wait_row_entry(input int r, output bit ok);
    logic [3:0] prev;
    ok = 1'b0;
    prev = fila;
    for (int i = 0; i < 40; i++) begin
      @(negedge CLK);
      if (fila == row_drive(r) && prev != row_drive(r)) begin
        ok = 1'b1;
        return;
      end
      prev = fila;
    end
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    key_down = '0;
    cyc(2);
    checks++; if (fila !== 4'b1110) $display("[TB] FAIL reset_fila: got %b expected %b", fila, 4'b1110); else passes++;
    checks++; if (tvalida !== 4'b1111) $display("[TB] FAIL reset_tvalida: got %b expected %b", tvalida, 4'b1111); else passes++;
    checks++; if (esnumero !== 1'b0) $display("[TB] FAIL reset_esnumero: got %b expected 0", esnumero); else passes++;
    checks++; if (tecla_lista !== 1'b0) $display("[TB] FAIL reset_strobe: got %b expected 0", tecla_lista); else passes++;
    Reset = 1'b0;
  endtask

  task automatic test_rotation();
    logic [3:0] prev;
    int gap;
    prev = fila;
    for (int k = 1; k <= 4; k++) begin
      gap = 0;
      for (int i = 0; i < 20; i++) begin
        @(negedge CLK);
        gap++;
        if (fila != prev) break;
      end
      checks++; if (fila !== row_drive(k % 4)) $display("[TB] FAIL rotation_value%0d: got %b expected %b", k, fila, row_drive(k % 4)); else passes++;
      checks++; if (gap != SCAN_DIV) $display("[TB] FAIL rotation_gap%0d: got %0d expected %0d", k, gap, SCAN_DIV); else passes++;
      prev = fila;
    end
  endtask

  task automatic test_key_c();
    int s0;
    s0 = strobe_cnt;
    key_down[2*4+3] = 1'b1;
    cyc(60);
    checks++; if (strobe_cnt - s0 != 1) $display("[TB] FAIL keyc_strobes: got %0d expected 1", strobe_cnt - s0); else passes++;
    checks++; if (tvalida !== ref_code(2, 3)) $display("[TB] FAIL keyc_tvalida: got %b expected %b", tvalida, ref_code(2, 3)); else passes++;
    checks++; if (esnumero !== 1'b0) $display("[TB] FAIL keyc_esnumero: got %b expected 0", esnumero); else passes++;
    key_down = '0;
    cyc(40);
  endtask

  task automatic test_held_key();
    int s0;
    s0 = strobe_cnt;
    key_down[3*4+1] = 1'b1;
    cyc(60);
    checks++; if (strobe_cnt - s0 != 1) $display("[TB] FAIL held_strobes: got %0d expected 1", strobe_cnt - s0); else passes++;
    checks++; if (strobe_code !== ref_code(3, 1)) $display("[TB] FAIL held_strobe_code: got %b expected %b", strobe_code, ref_code(3, 1)); else passes++;
    checks++; if (esnumero !== 1'b1) $display("[TB] FAIL held_esnumero: got %b expected 1", esnumero); else passes++;
    cyc(20 * SCAN_DIV);
    checks++; if (strobe_cnt - s0 != 1) $display("[TB] FAIL held_no_repeat: got %0d strobes expected 1", strobe_cnt - s0); else passes++;
    checks++; if (tvalida !== 4'b0000) $display("[TB] FAIL held_tvalida: got %b expected 0000", tvalida); else passes++;
    key_down = '0;
    cyc(40);
  endtask

  task automatic test_bounce();
    int s0;
    bit ok;
    logic [3:0] tv0;
    logic [3:0] prev;
    s0 = strobe_cnt;
    tv0 = tvalida;
    wait_row_entry(1, ok);
    checks++; if (!ok) $display("[TB] FAIL bounce_row_wait: got timeout expected row1"); else passes++;
    key_down[1*4+0] = 1'b1;
    cyc(5);
    key_down = '0;
    prev = fila;
    for (int i = 0; i < 8; i++) begin
      @(negedge CLK);
      if (fila != prev) break;
    end
    checks++; if (fila !== row_drive(2)) $display("[TB] FAIL bounce_resume: got %b expected %b", fila, row_drive(2)); else passes++;
    cyc(20);
    checks++; if (strobe_cnt != s0) $display("[TB] FAIL bounce_strobes: got %0d expected 0", strobe_cnt - s0); else passes++;
    checks++; if (tvalida !== tv0) $display("[TB] FAIL bounce_tvalida: got %b expected %b", tvalida, tv0); else passes++;
  endtask

  task automatic test_two_columns();
    int s0;
    logic [3:0] tv0;
    logic [3:0] f0;
    s0 = strobe_cnt;
    tv0 = tvalida;
    key_down[1*4+2] = 1'b1;
    key_down[1*4+3] = 1'b1;
    cyc(60);
    checks++; if (strobe_cnt != s0) $display("[TB] FAIL twocol_strobes: got %0d expected 0", strobe_cnt - s0); else passes++;
    checks++; if (tvalida !== tv0) $display("[TB] FAIL twocol_tvalida: got %b expected %b", tvalida, tv0); else passes++;
    f0 = fila;
    cyc(SCAN_DIV);
    checks++; if (fila === f0) $display("[TB] FAIL twocol_rotating: got %b expected a different row", fila); else passes++;
    key_down = '0;
    cyc(20);
  endtask

  task automatic test_reset_in_debounce();
    int s0;
    bit ok;
    wait_row_entry(2, ok);
    checks++; if (!ok) $display("[TB] FAIL rstdeb_row_wait: got timeout expected row2"); else passes++;
    s0 = strobe_cnt;
    key_down[2*4+1] = 1'b1;
    cyc(6);
    Reset = 1'b1;
    cyc(1);
    key_down = '0;
    cyc(1);
    checks++; if (fila !== 4'b1110) $display("[TB] FAIL rstdeb_fila: got %b expected 1110", fila); else passes++;
    checks++; if (tvalida !== 4'b1111) $display("[TB] FAIL rstdeb_tvalida: got %b expected 1111", tvalida); else passes++;
    checks++; if (esnumero !== 1'b0) $display("[TB] FAIL rstdeb_esnumero: got %b expected 0", esnumero); else passes++;
    Reset = 1'b0;
    cyc(40);
    checks++; if (strobe_cnt != s0) $display("[TB] FAIL rstdeb_strobes: got %0d expected 0", strobe_cnt - s0); else passes++;
    checks++; if (tvalida !== 4'b1111) $display("[TB] FAIL rstdeb_hold: got %b expected 1111", tvalida); else passes++;
  endtask

  task automatic test_release();
    int s0;
    logic [3:0] exp_tv;
    logic       exp_es;
    s0 = strobe_cnt;
    key_down[1*4+1] = 1'b1;
    cyc(60);
    checks++; if (tvalida !== ref_code(1, 1)) $display("[TB] FAIL release_press: got %b expected %b", tvalida, ref_code(1, 1)); else passes++;
    key_down = '0;
    cyc(40);
`ifdef KEYPAD_RELEASE_CLEAR_EN
    exp_tv = 4'b1111;
    exp_es = 1'b0;
`else
    exp_tv = ref_code(1, 1);
    exp_es = 1'b1;
`endif
    checks++; if (tvalida !== exp_tv) $display("[TB] FAIL release_tvalida: got %b expected %b", tvalida, exp_tv); else passes++;
    checks++; if (esnumero !== exp_es) $display("[TB] FAIL release_esnumero: got %b expected %b", esnumero, exp_es); else passes++;
    checks++; if (strobe_cnt - s0 != 1) $display("[TB] FAIL release_strobes: got %0d expected 1", strobe_cnt - s0); else passes++;
  endtask

  task automatic test_random();
    int k, r, c, s0;
    logic [3:0] exp_code;
    for (int n = 0; n < 10; n++) begin
      k = int'($urandom_range(15));
      r = k / 4;
      c = k % 4;
      exp_code = ref_code(r, c);
      s0 = strobe_cnt;
      key_down = '0;
      key_down[k] = 1'b1;
      cyc(60);
      checks++; if (strobe_cnt - s0 != 1) $display("[TB] FAIL rand%0d_strobes: got %0d expected 1", n, strobe_cnt - s0); else passes++;
      checks++; if (strobe_code !== exp_code) $display("[TB] FAIL rand%0d_code: got %b expected %b", n, strobe_code, exp_code); else passes++;
      checks++; if (strobe_es !== ref_esnum(exp_code)) $display("[TB] FAIL rand%0d_esnumero: got %b expected %b", n, strobe_es, ref_esnum(exp_code)); else passes++;
      key_down = '0;
      cyc(40);
`ifdef KEYPAD_RELEASE_CLEAR_EN
      checks++; if (tvalida !== 4'b1111) $display("[TB] FAIL rand%0d_after_release: got %b expected 1111", n, tvalida); else passes++;
`else
      checks++; if (tvalida !== exp_code) $display("[TB] FAIL rand%0d_after_release: got %b expected %b", n, tvalida, exp_code); else passes++;
`endif
    end
  endtask

  // Test sequence.
  initial begin
    test_reset();
    test_rotation();
    test_key_c();
    test_held_key();
    test_bounce();
    test_two_columns();
    test_reset_in_debounce();
    test_release();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
